// File: rtl/pc_sequencer.sv
// pc_sequencer
//
// Program counter sequencer for the single-cycle processor. Each cycle it
// selects the next PC: either the sequential successor (PC + STEP) or the
// branch/jump target (PC + STEP + sign-extended word offset). While memory
// holds BUSYWAIT high the PC is frozen and the branch decision taken at stall
// entry is held until the stall ends. A one-cycle REDIRECT pulse follows every
// taken target load and RETIRED counts completed instructions.
//
// Parameters:
//   RESET_VECTOR : PC value loaded on reset (first fetch address)
//   STEP         : byte increment per sequential instruction (must be 4)
//
// Ports:
//   CLK        in   system clock, all state updates on rising edge
//   RESET      in   synchronous active-low reset
//   BUSYWAIT   in   memory stall, 1 = current instruction not complete
//   JUMP       in   unconditional jump
//   BRANCH_EQ  in   beq instruction
//   BRANCH_NE  in   bne instruction
//   ZERO       in   ALU zero flag
//   OFFSET     in   8-bit signed word offset
//   PC         out  current instruction address
//   PC_VALID   out  fetch enable, low only while booting
//   REDIRECT   out  one-cycle pulse after a taken jump/branch
//   RETIRED    out  completed instruction count, wraps mod 2^16

module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned STEP         = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BUSYWAIT,
  input  logic        JUMP,
  input  logic        BRANCH_EQ,
  input  logic        BRANCH_NE,
  input  logic        ZERO,
  input  logic [7:0]  OFFSET,
  output logic [31:0] PC,
  output logic        PC_VALID,
  output logic        REDIRECT,
  output logic [15:0] RETIRED
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t      state_q,       state_d;
  logic [31:0] pc_q,          pc_d;
  logic        pc_valid_q,    pc_valid_d;
  logic        redirect_q,    redirect_d;
  logic [15:0] retired_q,     retired_d;
  logic        pend_take_q,   pend_take_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic        take;
  logic [31:0] seq_pc;
  logic [31:0] target_pc;
  logic [31:0] next_pc;

  // Branch decision and candidate addresses. JUMP and the branch terms are
  // simply OR'ed: every taken case resolves to the same target address.
  always_comb begin
    take      = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO);
    seq_pc    = pc_q + 32'(STEP);
    target_pc = seq_pc + {{22{OFFSET[7]}}, OFFSET, 2'b00};
    next_pc   = take ? target_pc : seq_pc;
  end

  // Next-state logic. Control inputs are only consulted in RUN; in STALL the
  // decision captured on entry is replayed when BUSYWAIT drops.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_valid_d    = pc_valid_q;
    redirect_d    = 1'b0;
    retired_d     = retired_q;
    pend_take_d   = pend_take_q;
    pend_target_d = pend_target_q;

    unique case (state_q)
      BOOT: begin
        // The reset vector itself is the first fetch, so the PC stays put.
        state_d    = RUN;
        pc_valid_d = 1'b1;
      end
      RUN: begin
        if (BUSYWAIT) begin
          pend_take_d   = take;
          pend_target_d = next_pc;
          state_d       = STALL;
        end else begin
          pc_d       = next_pc;
          retired_d  = retired_q + 16'd1;
          redirect_d = take;
        end
      end
      STALL: begin
        if (!BUSYWAIT) begin
          pc_d       = pend_target_q;
          retired_d  = retired_q + 16'd1;
          redirect_d = pend_take_q;
          state_d    = RUN;
        end
      end
      default: begin
        state_d    = BOOT;
        pc_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset overrides
  // everything, including a pending branch captured mid-stall.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      pc_valid_q    <= 1'b0;
      redirect_q    <= 1'b0;
      retired_q     <= 16'd0;
      pend_take_q   <= 1'b0;
      pend_target_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_valid_q    <= pc_valid_d;
      redirect_q    <= redirect_d;
      retired_q     <= retired_d;
      pend_take_q   <= pend_take_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign PC       = pc_q;
  assign PC_VALID = pc_valid_q;
  assign REDIRECT = redirect_q;
  assign RETIRED  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//
// Scoreboard bench for pc_sequencer. The driver applies inputs on the falling
// edge, advances a behavioural model of the sequencer by one clock and pushes
// the outputs the model predicts after the coming rising edge. The monitor
// samples the DUT shortly after every rising edge and compares it with the
// oldest queued prediction.

module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0040;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        redirect;
    logic [15:0] retired;
  } expect_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        BUSYWAIT;
  logic        JUMP;
  logic        BRANCH_EQ;
  logic        BRANCH_NE;
  logic        ZERO;
  logic [7:0]  OFFSET;
  logic [31:0] PC;
  logic        PC_VALID;
  logic        REDIRECT;
  logic [15:0] RETIRED;

  int checks = 0;
  int errors = 0;

  expect_t expQ[$];

  // Reference model state: what the sequencer should show after each edge.
  logic [31:0] mPc       = RV;
  logic        mBooted   = 1'b0;
  logic        mStalled  = 1'b0;
  logic        mValid    = 1'b0;
  logic        mRedirect = 1'b0;
  logic [15:0] mRetired  = 16'd0;
  logic        mPendTake = 1'b0;
  logic [31:0] mPendPc   = 32'd0;

  pc_sequencer #(.RESET_VECTOR(RV), .STEP(4)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BUSYWAIT  (BUSYWAIT),
    .JUMP      (JUMP),
    .BRANCH_EQ (BRANCH_EQ),
    .BRANCH_NE (BRANCH_NE),
    .ZERO      (ZERO),
    .OFFSET    (OFFSET),
    .PC        (PC),
    .PC_VALID  (PC_VALID),
    .REDIRECT  (REDIRECT),
    .RETIRED   (RETIRED)
  );

  always #5 CLK = ~CLK;

  // One clock of the behavioural model, written from the rules in plain
  // arithmetic: word offset times four added to the address of the next word.
  task automatic modelStep();
    bit          taken;
    logic [31:0] nextSeq;
    logic [31:0] nextTgt;
    if (!RESET) begin
      mPc = RV; mBooted = 0; mStalled = 0; mValid = 0;
      mRedirect = 0; mRetired = 0; mPendTake = 0; mPendPc = 0;
    end else if (!mBooted) begin
      mBooted = 1; mValid = 1; mRedirect = 0;
    end else if (!mStalled) begin
      taken   = JUMP || (BRANCH_EQ && ZERO) || (BRANCH_NE && !ZERO);
      nextSeq = mPc + 32'd4;
      nextTgt = nextSeq + 32'(int'($signed(OFFSET)) * 4);
      if (BUSYWAIT) begin
        mStalled  = 1;
        mPendTake = taken;
        mPendPc   = taken ? nextTgt : nextSeq;
        mRedirect = 0;
      end else begin
        mPc       = taken ? nextTgt : nextSeq;
        mRetired  = mRetired + 16'd1;
        mRedirect = taken;
      end
    end else if (!BUSYWAIT) begin
      mPc       = mPendPc;
      mRetired  = mRetired + 16'd1;
      mRedirect = mPendTake;
      mStalled  = 0;
    end
  endtask

  // Drive one cycle of inputs, predict the result, then wait for the next
  // falling edge where the following cycle's inputs are applied.
  task automatic applyStimulus(input logic rst, input logic busy, input logic jmp,
                               input logic beq, input logic bne, input logic zro,
                               input logic [7:0] off);
    expect_t e;
    RESET = rst; BUSYWAIT = busy; JUMP = jmp;
    BRANCH_EQ = beq; BRANCH_NE = bne; ZERO = zro; OFFSET = off;
    modelStep();
    e.pc = mPc; e.valid = mValid; e.redirect = mRedirect; e.retired = mRetired;
    expQ.push_back(e);
    @(negedge CLK);
  endtask

  // Jump from the current (running, unstalled) PC to addr.
  task automatic goTo(input logic [31:0] addr);
    logic [31:0] diff;
    diff = addr - (mPc + 32'd4);
    applyStimulus(1, 0, 1, 0, 0, 0, diff[9:2]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, required, $time);
    end
  endtask

  // Monitor: every rising edge produces a full set of registered outputs.
  initial begin
    expect_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (expQ.size() == 0) begin
        checkOutput("queue_underflow", 32'd0, 32'd1);
      end else begin
        e = expQ.pop_front();
        checkOutput("PC",       PC,              e.pc);
        checkOutput("PC_VALID", 32'(PC_VALID),   32'(e.valid));
        checkOutput("REDIRECT", 32'(REDIRECT),   32'(e.redirect));
        checkOutput("RETIRED",  32'(RETIRED),    32'(e.retired));
      end
    end
  end

  initial begin
    int guard;
    $display("[TB] start");

    // Reset held for three edges, then boot and the first sequential step.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 0, 0, 0, 8'h00);
    idle(1);

    // Backward jump from 0x10 with offset -2 words.
    goTo(32'h10);
    applyStimulus(1, 0, 1, 0, 0, 0, 8'hFE);
    idle(2);

    // The four branch condition cases at 0x20 with offset 3.
    goTo(32'h20); applyStimulus(1, 0, 0, 1, 0, 0, 8'h03);
    goTo(32'h20); applyStimulus(1, 0, 0, 1, 0, 1, 8'h03);
    goTo(32'h20); applyStimulus(1, 0, 0, 0, 1, 0, 8'h03);
    goTo(32'h20); applyStimulus(1, 0, 0, 0, 1, 1, 8'h03);
    idle(1);

    // Taken branch captured at stall entry; glitching controls are ignored.
    goTo(32'h08);
    applyStimulus(1, 1, 0, 1, 0, 1, 8'h02);
    applyStimulus(1, 1, 1, 1, 0, 0, 8'h02);
    applyStimulus(1, 1, 0, 1, 0, 0, 8'h7F);
    applyStimulus(1, 1, 1, 0, 1, 1, 8'h80);
    applyStimulus(1, 0, 0, 0, 0, 0, 8'h00);
    idle(1);

    // Single-cycle busy pulse without a branch.
    applyStimulus(1, 1, 0, 0, 0, 0, 8'h00);
    idle(2);

    // PC wraps past the top of the address space.
    goTo(32'hFFFF_FFFC);
    idle(2);

    // Reset arriving mid-stall discards the pending branch.
    applyStimulus(1, 1, 0, 1, 0, 1, 8'h10);
    applyStimulus(1, 1, 0, 0, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 0, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 0, 0, 0, 8'h00);
    idle(3);

    // Randomized traffic, including occasional resets and long stalls.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom),
                    1'($urandom), 8'($urandom));
    end

    // Drive RETIRED up to 0xFFFF and across the wrap.
    applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 0, 0, 0, 8'h00);
    while (mRetired != 16'hFFFF) begin
      applyStimulus(1, 0, ($urandom_range(0, 7) == 0), 0, 0, 0, 8'($urandom));
    end
    idle(3);

    guard = 0;
    while (expQ.size() != 0 && guard < 10) begin
      @(negedge CLK);
      guard++;
    end
    if (expQ.size() != 0) checkOutput("queue_drain", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
